// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register and its payload slot.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Occupancy of a stage: nothing held, main entry only, main plus skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

  // addi x0, x0, 0 -- the canonical RV32I NOP.
  localparam logic [31:0] RV_NOP   = 32'h0000_0013;

  localparam int unsigned DEF_XLEN = 32;

endpackage : pipe_pkg

// File: rtl/pipe_slot.sv
// One payload register {valid, pc, instr, side} with load, clear-to-bubble and hold.
// Latency: 1 cycle from load to q_*.
// Backpressure: none; the owner decides when to load, clear or hold.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset (reset = bubble)
//   clr             clear to bubble (wins over load)
//   load            capture d_pc/d_instr/d_side and set valid
//   d_*             payload to capture
//   q_valid, q_*    registered payload; bubble = {0, 0, NOP_INSTR, 0}
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned      XLEN      = DEF_XLEN,
  parameter int unsigned      SIDE_W    = 8,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(RV_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic [XLEN-1:0]   d_pc,
  input  logic [XLEN-1:0]   d_instr,
  input  logic [SIDE_W-1:0] d_side,
  output logic              q_valid,
  output logic [XLEN-1:0]   q_pc,
  output logic [XLEN-1:0]   q_instr,
  output logic [SIDE_W-1:0] q_side
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q,    pc_d;
  logic [XLEN-1:0]   instr_q, instr_d;
  logic [SIDE_W-1:0] side_q,  side_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    side_d  = side_q;
    if (clr) begin
      // The NOP is stored rather than muxed on the output, so q_instr stays a
      // pure flop output.
      valid_d = 1'b0;
      pc_d    = '0;
      instr_d = NOP_INSTR;
      side_d  = '0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = d_pc;
      instr_d = d_instr;
      side_d  = d_side;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      side_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      side_q  <= side_d;
    end
  end

  assign q_valid = valid_q;
  assign q_pc    = pc_q;
  assign q_instr = instr_q;
  assign q_side  = side_q;

endmodule : pipe_slot

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register (PC, instruction, sideband) with stall, flush and optional skid entry.
// Latency: 1 cycle push-to-OUT_VALID when empty; 1 entry/cycle sustained throughput.
// Backpressure: SKID_EN=1 -> IN_READY is a flop (~skid valid), the skid absorbs the in-flight entry;
//               SKID_EN=0 -> IN_READY = ~main valid | accept (combinational from OUT_READY/STALL).
//
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   FLUSH, STALL          hazard-unit squash / hold of the downstream transfer
//   IN_VALID/IN_READY     upstream handshake with IN_PC, IN_INSTR, IN_SIDE
//   OUT_VALID/OUT_READY   downstream handshake with OUT_PC, OUT_INSTR, OUT_SIDE
//   SKID_FULL             skid entry occupied (always 0 when SKID_EN=0)
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned     XLEN      = DEF_XLEN,
  parameter int unsigned     SIDE_W    = 8,
  parameter bit              SKID_EN   = 1'b1,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(RV_NOP)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              FLUSH,
  input  logic              STALL,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [XLEN-1:0]   IN_PC,
  input  logic [XLEN-1:0]   IN_INSTR,
  input  logic [SIDE_W-1:0] IN_SIDE,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [XLEN-1:0]   OUT_PC,
  output logic [XLEN-1:0]   OUT_INSTR,
  output logic [SIDE_W-1:0] OUT_SIDE,
  output logic              SKID_FULL
);

  pipe_state_e state_q, state_d;

  logic              push, accept, in_ready;
  logic              main_valid;
  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic              skid_valid;
  logic [XLEN-1:0]   skid_pc, skid_instr;
  logic [SIDE_W-1:0] skid_side;
  logic [XLEN-1:0]   main_d_pc, main_d_instr;
  logic [SIDE_W-1:0] main_d_side;

  assign accept = main_valid & OUT_READY & ~STALL;
  assign push   = IN_VALID & in_ready;

  generate
    if (SKID_EN) begin : g_ready_reg
      assign in_ready = ~skid_valid;
    end else begin : g_ready_comb
      assign in_ready = ~main_valid | accept;
    end
  endgenerate

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (FLUSH) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (push) state_d = ST_FULL;
        ST_FULL: begin
          // Without a skid, push while held implies accept (IN_READY gating),
          // so the push & ~accept leg never fires in that build.
          if (push && !accept)      state_d = SKID_EN ? ST_SKID : ST_FULL;
          else if (!push && accept) state_d = ST_EMPTY;
        end
        ST_SKID:  if (accept) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Slot control outputs
  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (FLUSH) begin
      // Any push in this cycle is consumed by the handshake but dropped here.
      main_clr = 1'b0 | 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: main_load = push;
        ST_FULL: begin
          if (push && accept)          main_load = 1'b1;
          else if (push && SKID_EN)    skid_load = 1'b1;
          else if (accept)             main_clr  = 1'b1;
        end
        ST_SKID: begin
          // Skid holds the younger entry; it moves up to keep FIFO order.
          if (accept) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: main_clr = 1'b1;
      endcase
    end
  end

  assign main_d_pc    = main_from_skid ? skid_pc    : IN_PC;
  assign main_d_instr = main_from_skid ? skid_instr : IN_INSTR;
  assign main_d_side  = main_from_skid ? skid_side  : IN_SIDE;

  pipe_slot #(
    .XLEN      (XLEN),
    .SIDE_W    (SIDE_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_main (
    .clk     (CLK),
    .rst     (RESET),
    .clr     (main_clr),
    .load    (main_load),
    .d_pc    (main_d_pc),
    .d_instr (main_d_instr),
    .d_side  (main_d_side),
    .q_valid (main_valid),
    .q_pc    (OUT_PC),
    .q_instr (OUT_INSTR),
    .q_side  (OUT_SIDE)
  );

  generate
    if (SKID_EN) begin : g_skid
      pipe_slot #(
        .XLEN      (XLEN),
        .SIDE_W    (SIDE_W),
        .NOP_INSTR (NOP_INSTR)
      ) u_skid (
        .clk     (CLK),
        .rst     (RESET),
        .clr     (skid_clr),
        .load    (skid_load),
        .d_pc    (IN_PC),
        .d_instr (IN_INSTR),
        .d_side  (IN_SIDE),
        .q_valid (skid_valid),
        .q_pc    (skid_pc),
        .q_instr (skid_instr),
        .q_side  (skid_side)
      );
    end else begin : g_no_skid
      logic unused_skid_ctrl;
      assign unused_skid_ctrl = skid_load | skid_clr;
      assign skid_valid = 1'b0;
      assign skid_pc    = '0;
      assign skid_instr = NOP_INSTR;
      assign skid_side  = '0;
    end
  endgenerate

  assign IN_READY  = in_ready;
  assign OUT_VALID = main_valid;
  assign SKID_FULL = skid_valid;

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID_EN=1 instance (a_*) and SKID_EN=0 instance (b_*).
// Directed stimulus; a negedge monitor scoreboards every downstream transfer.
// Inputs driven #1 after posedge, outputs sampled away from the edge.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [7:0]  side;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_flush, a_stall, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_skid_full;
  logic [31:0] a_in_pc, a_in_instr, a_out_pc, a_out_instr;
  logic [7:0]  a_in_side, a_out_side;
  logic        b_flush, b_stall, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_skid_full;
  logic [31:0] b_in_pc, b_in_instr, b_out_pc, b_out_instr;
  logic [7:0]  b_in_side, b_out_side;

  pipe_stage_reg #(.XLEN(32), .SIDE_W(8), .SKID_EN(1'b1), .NOP_INSTR(NOP)) u_a (
    .CLK(clk), .RESET(rst), .FLUSH(a_flush), .STALL(a_stall),
    .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN_PC(a_in_pc), .IN_INSTR(a_in_instr),
    .IN_SIDE(a_in_side), .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_PC(a_out_pc),
    .OUT_INSTR(a_out_instr), .OUT_SIDE(a_out_side), .SKID_FULL(a_skid_full));

  pipe_stage_reg #(.XLEN(32), .SIDE_W(8), .SKID_EN(1'b0), .NOP_INSTR(NOP)) u_b (
    .CLK(clk), .RESET(rst), .FLUSH(b_flush), .STALL(b_stall),
    .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_PC(b_in_pc), .IN_INSTR(b_in_instr),
    .IN_SIDE(b_in_side), .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .OUT_PC(b_out_pc),
    .OUT_INSTR(b_out_instr), .OUT_SIDE(b_out_side), .SKID_FULL(b_skid_full));

  int vectors = 0;
  int miscompares = 0;

  ent_t a_q[$];
  ent_t b_q[$];
  logic a_prev_hold = 1'b0, b_prev_hold = 1'b0;
  ent_t a_prev, b_prev;

  function automatic logic [31:0] instr_of(logic [31:0] pc);
    return 32'h0000_0033 | (pc << 7);
  endfunction

  function automatic logic [7:0] side_of(logic [31:0] pc);
    return pc[9:2];
  endfunction

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(logic v, logic [31:0] pc);
    a_in_valid = v; a_in_pc = pc; a_in_instr = instr_of(pc); a_in_side = side_of(pc);
  endtask

  task automatic drive_b(logic v, logic [31:0] pc);
    b_in_valid = v; b_in_pc = pc; b_in_instr = instr_of(pc); b_in_side = side_of(pc);
  endtask

  // Scoreboard monitor: pop on each downstream transfer, push on each upstream
  // transfer, drop everything on flush; held outputs must not move.
  always @(negedge clk) begin
    ent_t got, exp;
    if (rst) begin
      a_prev_hold = 1'b0;
      b_prev_hold = 1'b0;
    end else begin
      got = '{pc: a_out_pc, instr: a_out_instr, side: a_out_side};
      if (a_prev_hold) chk("a_stable", got, a_prev);
      if (a_out_valid && a_out_ready && !a_stall && !a_flush) begin
        if (a_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL a_unexpected: got pc %h expected no transfer", a_out_pc);
        end else begin
          exp = a_q.pop_front();
          chk("a_out", got, exp);
        end
      end
      if (!a_out_valid) chk("a_bubble", got, {32'h0, NOP, 8'h0});
      if (a_in_valid && a_in_ready && !a_flush)
        a_q.push_back('{pc: a_in_pc, instr: a_in_instr, side: a_in_side});
      if (a_flush) a_q.delete();
      a_prev_hold = a_out_valid && !(a_out_ready && !a_stall) && !a_flush;
      a_prev = got;

      got = '{pc: b_out_pc, instr: b_out_instr, side: b_out_side};
      if (b_prev_hold) chk("b_stable", got, b_prev);
      if (b_out_valid && b_out_ready && !b_stall && !b_flush) begin
        if (b_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL b_unexpected: got pc %h expected no transfer", b_out_pc);
        end else begin
          exp = b_q.pop_front();
          chk("b_out", got, exp);
        end
      end
      if (!b_out_valid) chk("b_bubble", got, {32'h0, NOP, 8'h0});
      if (b_in_valid && b_in_ready && !b_flush)
        b_q.push_back('{pc: b_in_pc, instr: b_in_instr, side: b_in_side});
      if (b_flush) b_q.delete();
      b_prev_hold = b_out_valid && !(b_out_ready && !b_stall) && !b_flush;
      b_prev = got;
      chk("b_skid_const0", 72'(b_skid_full), 72'd0);
    end
  end

  initial begin
    rst = 1'b1;
    a_flush = 0; a_stall = 0; a_out_ready = 1;
    b_flush = 0; b_stall = 0; b_out_ready = 1;
    drive_a(1, 32'h100);
    drive_b(1, 32'h100);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_a(0, 0);
    drive_b(0, 0);

    // Reset state
    chk("rst_a_valid", 72'(a_out_valid), 72'd0);
    chk("rst_a_instr", 72'(a_out_instr), 72'(NOP));
    chk("rst_a_pc", 72'(a_out_pc), 72'd0);
    chk("rst_a_side", 72'(a_out_side), 72'd0);
    chk("rst_a_in_ready", 72'(a_in_ready), 72'd1);
    chk("rst_a_skid", 72'(a_skid_full), 72'd0);
    chk("rst_b_in_ready", 72'(b_in_ready), 72'd1);
    chk("rst_b_valid", 72'(b_out_valid), 72'd0);
    cyc();
    chk("rst_a_no_0x100", 72'(a_out_valid), 72'd0);

    // Streaming, 1-cycle latency, full throughput
    for (int i = 0; i < 4; i++) begin
      drive_a(1, 32'(4 * i));
      cyc();
      chk("strm_valid", 72'(a_out_valid), 72'd1);
      chk("strm_pc", 72'(a_out_pc), 72'(4 * i));
    end
    drive_a(0, 0);
    cyc();
    chk("strm_end_valid", 72'(a_out_valid), 72'd0);

    // Back-pressure into the skid entry
    a_out_ready = 0;
    drive_a(1, 32'h10);
    cyc();
    chk("bp_pc10", 72'(a_out_pc), 72'h10);
    chk("bp_skid0", 72'(a_skid_full), 72'd0);
    chk("bp_rdy1", 72'(a_in_ready), 72'd1);
    drive_a(1, 32'h14);
    cyc();
    chk("bp_skid1", 72'(a_skid_full), 72'd1);
    chk("bp_rdy0", 72'(a_in_ready), 72'd0);
    chk("bp_hold10", 72'(a_out_pc), 72'h10);
    drive_a(1, 32'h18);
    cyc();
    chk("bp_hold10b", 72'(a_out_pc), 72'h10);
    chk("bp_rdy0b", 72'(a_in_ready), 72'd0);
    a_out_ready = 1;
    cyc();
    chk("bp_pc14", 72'(a_out_pc), 72'h14);
    chk("bp_skid_drain", 72'(a_skid_full), 72'd0);
    chk("bp_rdy_back", 72'(a_in_ready), 72'd1);
    cyc();
    chk("bp_pc18", 72'(a_out_pc), 72'h18);
    drive_a(0, 0);
    cyc();
    chk("bp_empty", 72'(a_out_valid), 72'd0);

    // Stall for 3 cycles with OUT_READY high
    drive_a(1, 32'h20);
    cyc();
    chk("st_pc20", 72'(a_out_pc), 72'h20);
    a_stall = 1;
    drive_a(1, 32'h24);
    cyc();
    drive_a(0, 0);
    chk("st_hold1", {a_out_pc, a_out_instr}, {32'h20, instr_of(32'h20)});
    cyc();
    chk("st_hold2", {a_out_pc, a_out_instr}, {32'h20, instr_of(32'h20)});
    cyc();
    chk("st_hold3", {a_out_pc, a_out_instr}, {32'h20, instr_of(32'h20)});
    a_stall = 0;
    cyc();
    chk("st_next24", {a_out_valid, a_out_pc}, {1'b1, 32'h24});
    cyc();
    chk("st_empty", 72'(a_out_valid), 72'd0);

    // Flush while in the skid state, with 0x40 offered
    a_out_ready = 0;
    drive_a(1, 32'h30);
    cyc();
    drive_a(1, 32'h34);
    cyc();
    chk("fl_skid1", 72'(a_skid_full), 72'd1);
    a_flush = 1;
    drive_a(1, 32'h40);
    cyc();
    a_flush = 0;
    drive_a(0, 0);
    chk("fl_valid0", 72'(a_out_valid), 72'd0);
    chk("fl_nop", 72'(a_out_instr), 72'(NOP));
    chk("fl_skid0", 72'(a_skid_full), 72'd0);
    chk("fl_rdy1", 72'(a_in_ready), 72'd1);
    a_out_ready = 1;
    repeat (3) cyc();
    chk("fl_no_0x40", 72'(a_out_valid), 72'd0);

    // Flush while full, with a real push in the same cycle
    a_out_ready = 0;
    drive_a(1, 32'h60);
    cyc();
    a_flush = 1;
    drive_a(1, 32'h64);
    cyc();
    a_flush = 0;
    drive_a(0, 0);
    chk("fl2_valid0", 72'(a_out_valid), 72'd0);
    chk("fl2_skid0", 72'(a_skid_full), 72'd0);
    a_out_ready = 1;
    cyc();
    chk("fl2_no_0x64", 72'(a_out_valid), 72'd0);

    // SKID_EN=0: combinational IN_READY and back-to-back replace
    b_out_ready = 0;
    drive_b(1, 32'h50);
    cyc();
    drive_b(0, 0);
    chk("b_pc50", {b_out_valid, b_out_pc}, {1'b1, 32'h50});
    chk("b_rdy0", 72'(b_in_ready), 72'd0);
    b_out_ready = 1;
    drive_b(1, 32'h54);
    #1;
    chk("b_rdy1_same", 72'(b_in_ready), 72'd1);
    cyc();
    drive_b(0, 0);
    chk("b_pc54", {b_out_valid, b_out_pc}, {1'b1, 32'h54});
    b_stall = 1;
    #1;
    chk("b_stall_rdy0", 72'(b_in_ready), 72'd0);
    b_stall = 0;
    cyc();
    chk("b_empty", 72'(b_out_valid), 72'd0);
    chk("b_rdy_empty", 72'(b_in_ready), 72'd1);

    repeat (2) cyc();
    chk("a_sb_drained", 72'(a_q.size()), 72'd0);
    chk("b_sb_drained", 72'(b_q.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_stage_reg
